// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI word sequencer.
package spi_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SEND,
        WAIT,
        HOLD,
        DONE
    } spi_ctrl_state_e;

    // Width of the shared down-counter: must hold the largest of the byte count
    // and the two slave-select guard intervals.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_word_ctrl.sv
// Word-level SPI sequencer: frames one word with ss, feeds the byte engine
// MSB byte first and assembles the returned MISO bytes into a response word.
module spi_word_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NBYTES   = 4,
    parameter int unsigned SS_SETUP = 2,
    parameter int unsigned SS_HOLD  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [BYTE_W*NBYTES-1:0]   req_wd,
    output logic                       rsp_valid,
    output logic [BYTE_W*NBYTES-1:0]   rsp_rd,
    output logic                       busy,
    output logic                       ss,
    output logic                       m_send,
    output logic [BYTE_W-1:0]          m_wd,
    input  logic                       m_busy,
    input  logic                       m_rdy,
    input  logic [BYTE_W-1:0]          m_rd
);

    localparam int unsigned WORD_W = BYTE_W * NBYTES;
    localparam int unsigned CNT_W  = cnt_width(NBYTES, SS_SETUP, SS_HOLD);

    // Counter reload values; guard intervals count down to zero inclusive.
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_BYTES = CNT_W'(NBYTES);
    localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'((SS_SETUP > 0) ? SS_SETUP - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'((SS_HOLD > 0) ? SS_HOLD - 1 : 0);

    spi_ctrl_state_e    state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  tx_q, tx_d;
    logic [WORD_W-1:0]  rx_q, rx_d;
    logic [WORD_W-1:0]  rsp_rd_q, rsp_rd_d;

    logic               last_byte;

    assign last_byte = (cnt_q == CNT_ONE);

    // State register; async reset returns to IDLE so ss/m_send drop at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = (SS_SETUP == 0) ? SEND : SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!m_busy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (m_rdy) begin
                    if (last_byte) begin
                        state_d = (SS_HOLD == 0) ? DONE : HOLD;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next-state: shared counter, tx/rx shift registers, response latch.
    always_comb begin
        cnt_d = cnt_q;
        tx_d  = tx_q;
        rx_d  = rx_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tx_d  = req_wd;
                    rx_d  = '0;
                    cnt_d = (SS_SETUP == 0) ? CNT_BYTES : CNT_SETUP;
                end
            end
            SETUP: begin
                // Counter switches from guard timing to byte counting here.
                cnt_d = (cnt_q == '0) ? CNT_BYTES : cnt_q - CNT_ONE;
            end
            WAIT: begin
                if (m_rdy) begin
                    rx_d  = (rx_q << BYTE_W) | WORD_W'(m_rd);
                    tx_d  = tx_q << BYTE_W;
                    cnt_d = last_byte ? CNT_HOLD : cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
            end
        endcase
        // Latch the response on entry to DONE so it is valid with rsp_valid.
        rsp_rd_d = (state_d == DONE) ? rx_d : rsp_rd_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rsp_rd_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rsp_rd_q <= rsp_rd_d;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        req_ready = (state_q == IDLE) && rst;
        busy      = (state_q != IDLE);
        rsp_valid = (state_q == DONE);
        rsp_rd    = rsp_rd_q;
        ss        = !((state_q == SETUP) || (state_q == SEND) ||
                      (state_q == WAIT)  || (state_q == HOLD));
        m_send    = (state_q == SEND) && !m_busy;
        m_wd      = m_send ? tx_q[WORD_W-1 -: BYTE_W] : '0;
    end

endmodule

// File: tb/tb_spi_word_ctrl.sv
// Scoreboard bench for spi_word_ctrl: behavioural byte engine + slave model,
// expected bytes/words queued by the stimulus and popped by monitors.
module tb_spi_word_ctrl;

    localparam int NB      = 4;
    localparam int A_SETUP = 2;
    localparam int A_HOLD  = 2;
    localparam int B_SETUP = 3;
    localparam int B_HOLD  = 0;
    localparam int ENG_LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A (default guard times)
    logic        req_valid, req_ready, rsp_valid, busy, ss, m_send, m_busy, m_rdy;
    logic [31:0] req_wd, rsp_rd;
    logic [7:0]  m_wd, m_rd;

    // DUT B (SS_SETUP=3, SS_HOLD=0)
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_busy, b_ss, b_m_send, b_m_busy, b_m_rdy;
    logic [31:0] b_req_wd, b_rsp_rd;
    logic [7:0]  b_m_wd, b_m_rd;

    spi_word_ctrl #(.NBYTES(NB), .SS_SETUP(A_SETUP), .SS_HOLD(A_HOLD)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wd(req_wd),
        .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .busy(busy), .ss(ss), .m_send(m_send),
        .m_wd(m_wd), .m_busy(m_busy), .m_rdy(m_rdy), .m_rd(m_rd)
    );

    spi_word_ctrl #(.NBYTES(NB), .SS_SETUP(B_SETUP), .SS_HOLD(B_HOLD)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_wd(b_req_wd), .rsp_valid(b_rsp_valid), .rsp_rd(b_rsp_rd), .busy(b_busy),
        .ss(b_ss), .m_send(b_m_send), .m_wd(b_m_wd), .m_busy(b_m_busy), .m_rdy(b_m_rdy),
        .m_rd(b_m_rd)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  exp_tx[$];
    logic [7:0]  slave_q[$];
    logic [31:0] exp_rsp[$];
    logic [31:0] b_exp_rsp[$];
    int          rdy_cnt = 0;
    int          rsp_cnt = 0;
    int          b_rsp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // Byte engine + slave model for DUT A; checks every byte put on the wire.
    int eng_cnt = 0;
    initial begin
        m_busy = 1'b0; m_rdy = 1'b0; m_rd = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                m_busy = 1'b0; m_rdy = 1'b0; eng_cnt = 0;
            end else begin
                m_rdy = 1'b0;
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt > 0) begin
                        m_busy = 1'b1;
                    end else begin
                        m_busy = 1'b0;
                        m_rdy  = 1'b1;
                        m_rd   = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
                        rdy_cnt++;
                    end
                end else if (m_send) begin
                    if (exp_tx.size() == 0) fail("tx_extra_byte");
                    else check("tx_byte", {24'h0, m_wd}, {24'h0, exp_tx.pop_front()});
                    eng_cnt = ENG_LAT + 1;
                end
            end
        end
    end

    // Byte engine for DUT B: fixed 0x5a reply, short latency.
    int b_eng_cnt = 0;
    initial begin
        b_m_busy = 1'b0; b_m_rdy = 1'b0; b_m_rd = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                b_m_busy = 1'b0; b_m_rdy = 1'b0; b_eng_cnt = 0;
            end else begin
                b_m_rdy = 1'b0;
                if (b_eng_cnt > 0) begin
                    b_eng_cnt--;
                    if (b_eng_cnt > 0) begin
                        b_m_busy = 1'b1;
                    end else begin
                        b_m_busy = 1'b0; b_m_rdy = 1'b1; b_m_rd = 8'h5a;
                    end
                end else if (b_m_send) begin
                    b_eng_cnt = 2;
                end
            end
        end
    end

    // Monitor A: response scoreboard and ss framing/timing.
    initial begin
        logic        prev_ss, pend_ready;
        int          acc_cyc, fall_cyc, last_rdy, nsent;
        logic [31:0] last_rsp;
        prev_ss = 1'b1; pend_ready = 1'b0; acc_cyc = 0; fall_cyc = 0; last_rdy = 0;
        nsent = 0; last_rsp = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_ss = 1'b1; pend_ready = 1'b0; nsent = 0; last_rsp = 32'h0;
            end else begin
                if (pend_ready) begin
                    check("ready_after_done", {31'h0, req_ready}, 32'h1);
                    pend_ready = 1'b0;
                end
                if (req_valid && req_ready) acc_cyc = cyc;
                if (prev_ss && !ss) begin
                    check("ss_fall_after_accept", cyc - acc_cyc, 1);
                    fall_cyc = cyc;
                    nsent = 0;
                end
                if (m_send) begin
                    check("ss_low_at_send", {31'h0, ss}, 32'h0);
                    if (nsent == 0) check("setup_cycles", cyc - fall_cyc, A_SETUP);
                    nsent++;
                end
                if (m_rdy) last_rdy = cyc;
                if (!prev_ss && ss) begin
                    check("hold_cycles", cyc - last_rdy, A_HOLD + 1);
                    check("bytes_per_word", nsent, NB);
                    check("rsp_at_ss_rise", {31'h0, rsp_valid}, 32'h1);
                end
                if (rsp_valid) begin
                    if (exp_rsp.size() == 0) fail("rsp_unexpected");
                    else check("rsp_rd", rsp_rd, exp_rsp.pop_front());
                    check("busy_in_done", {31'h0, busy}, 32'h1);
                    check("not_ready_in_done", {31'h0, req_ready}, 32'h0);
                    last_rsp = rsp_rd;
                    pend_ready = 1'b1;
                    rsp_cnt++;
                end else if (rsp_rd !== last_rsp) begin
                    fail("rsp_rd_stable");
                    last_rsp = rsp_rd;
                end
                prev_ss = ss;
            end
        end
    end

    // Monitor B: guard timing with SS_SETUP=3, SS_HOLD=0.
    initial begin
        logic prev_ss;
        int   fall_cyc, last_rdy, nsent;
        prev_ss = 1'b1; fall_cyc = 0; last_rdy = 0; nsent = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_ss = 1'b1; nsent = 0;
            end else begin
                if (prev_ss && !b_ss) begin
                    fall_cyc = cyc;
                    nsent = 0;
                end
                if (b_m_send) begin
                    if (nsent == 0) check("b_setup_cycles", cyc - fall_cyc, B_SETUP);
                    nsent++;
                end
                if (b_m_rdy) last_rdy = cyc;
                if (!prev_ss && b_ss) check("b_hold_cycles", cyc - last_rdy, B_HOLD + 1);
                if (b_rsp_valid) begin
                    if (b_exp_rsp.size() == 0) fail("b_rsp_unexpected");
                    else check("b_rsp_rd", b_rsp_rd, b_exp_rsp.pop_front());
                    b_rsp_cnt++;
                end
                prev_ss = b_ss;
            end
        end
    end

    // Queue expectations for one word, then present it until accepted.
    task automatic issue(input logic [31:0] wd, input logic [31:0] sbytes,
                         input logic [31:0] exp, input bit expect_rsp);
        int t;
        for (int i = 0; i < NB; i++) begin
            exp_tx.push_back(wd[31-8*i -: 8]);
            slave_q.push_back(sbytes[31-8*i -: 8]);
        end
        if (expect_rsp) exp_rsp.push_back(exp);
        @(posedge clk); #2;
        req_valid = 1'b1;
        req_wd    = wd;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready && t < 2000);
        if (!req_ready) fail("accept_timeout");
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_rsp.size() != 0 || !req_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) fail("done_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int base;
        rst = 1'b0;
        req_valid = 1'b0; req_wd = 32'h0;
        b_req_valid = 1'b0; b_req_wd = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ss", {31'h0, ss}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rd", rsp_rd, 32'h0);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_m_send", {31'h0, m_send}, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'h0, req_ready}, 32'h1);

        // Constant 0xaa slave reply
        issue(32'hdeadc0de, 32'haaaaaaaa, 32'haaaaaaaa, 1'b1);
        wait_done();

        // Distinct slave bytes
        issue(32'hc001beef, 32'h12345678, 32'h12345678, 1'b1);
        wait_done();

        // Second request presented while the first is in flight
        issue(32'h0f1e2d3c, 32'h9abcdef0, 32'h9abcdef0, 1'b1);
        issue(32'hdeadbeef, 32'h11223344, 32'h11223344, 1'b1);
        wait_done();

        // Reset after the second byte completes: no response expected
        base = rdy_cnt;
        issue(32'h55aa33cc, 32'h01020304, 32'h0, 1'b0);
        t = 0;
        while (rdy_cnt < base + 2 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) fail("abort_rdy_timeout");
        rst = 1'b0;
        #1;
        check("abort_ss", {31'h0, ss}, 32'h1);
        check("abort_m_send", {31'h0, m_send}, 32'h0);
        check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        exp_tx.delete();
        slave_q.delete();
        check("abort_rsp_rd", rsp_rd, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Normal transfer after the abort
        issue(32'h0badf00d, 32'hcafebabe, 32'hcafebabe, 1'b1);
        wait_done();

        // Guard timing on the second instance
        b_exp_rsp.push_back(32'h5a5a5a5a);
        @(posedge clk); #2;
        b_req_valid = 1'b1;
        b_req_wd    = 32'h13579bdf;
        @(negedge clk);
        check("b_ready", {31'h0, b_req_ready}, 32'h1);
        @(posedge clk); #2;
        b_req_valid = 1'b0;
        t = 0;
        while ((b_exp_rsp.size() != 0 || !b_req_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) fail("b_done_timeout");

        repeat (4) @(negedge clk);
        check("rsp_queue_drained", exp_rsp.size(), 0);
        check("tx_queue_drained", exp_tx.size(), 0);
        check("rsp_count", rsp_cnt, 5);
        check("b_rsp_count", b_rsp_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
